// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//   Fetch stage that sits right after program_counter. It accepts the current
//   PC, issues a read to the synchronous instruction memory, and buffers the
//   returned words in a small in-order queue. Decode takes {instr, instr_pc}
//   over a valid/ready handshake. A credit rule (queued + in-flight < DEPTH)
//   back-pressures the PC through pc_ready. A flush (taken branch) kills the
//   queued and in-flight fetches.
//
// Optional feature macro: FETCH_HALT_DETECT_EN
//   When defined, a pushed word equal to HALT_INSTR sets the sticky 'halted'
//   output and stops further accepts until a flush or reset.
//   When undefined, 'halted' is always 0 and there is no compare logic.
//
// Ports
//   clk          in   clock; every state update happens on posedge
//   reset        in   synchronous reset, active low (0 = reset)
//   pc_in        in   PC to fetch
//   pc_valid     in   pc_in is valid this cycle
//   pc_ready     out  fetch accepts pc_in this cycle
//   flush        in   taken branch; clears queue and in-flight read
//   imem_rd_en   out  instruction memory read strobe
//   imem_addr    out  instruction memory address (pc_in truncated, wraps)
//   imem_rdata   in   instruction memory data, valid the cycle after rd_en
//   instr_valid  out  queue head valid
//   instr_ready  in   decode consumes the head
//   instr        out  head instruction (holds last value while empty)
//   instr_pc     out  PC of head instruction (holds last value while empty)
//   halted       out  sticky halt flag (always 0 without the macro)
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int                 PC_W       = 32,
  parameter int                 IMEM_AW    = 12,
  parameter int                 INSTR_W    = 9,
  parameter int                 DEPTH      = 4,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               pc_valid,
  output logic               pc_ready,
  input  logic               flush,
  output logic               imem_rd_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic               inflight_q, inflight_d;
  logic [PC_W-1:0]    inflightPc_q, inflightPc_d;
  logic               halted_q, halted_d;
  logic [INSTR_W-1:0] holdInstr_q;
  logic [PC_W-1:0]    holdPc_q;

  logic [INSTR_W-1:0] instrMem_q [DEPTH];
  logic [PC_W-1:0]    pcMem_q    [DEPTH];

  logic [CNT_W:0] occupancy;
  logic           accept;
  logic           push;
  logic           pop;
  logic           haltHit;

  // Credit counts the in-flight read too, so a returning word always has a
  // free slot and the queue can never overflow.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign pc_ready  = reset && !flush && !halted_q && (occupancy < DEPTH_C);
  assign accept    = pc_valid && pc_ready;

  assign imem_rd_en = accept;
  assign imem_addr  = pc_in[IMEM_AW-1:0];

  // The word returning this cycle is dropped when flush or reset kills it.
  assign push = reset && !flush && inflight_q;
  assign pop  = !flush && (count_q != '0) && instr_ready;

`ifdef FETCH_HALT_DETECT_EN
  assign haltHit = push && (imem_rdata == HALT_INSTR);
`else
  logic unusedHaltInstr;
  assign unusedHaltInstr = ^HALT_INSTR;
  assign haltHit = 1'b0;
`endif

  assign halted      = halted_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? instrMem_q[rdPtr_q] : holdInstr_q;
  assign instr_pc    = instr_valid ? pcMem_q[rdPtr_q]    : holdPc_q;

  // Next-state for pointers, occupancy, in-flight tracking and halt.
  // Flush wins over push, pop and accept.
  always_comb begin
    count_d      = count_q;
    rdPtr_d      = rdPtr_q;
    wrPtr_d      = wrPtr_q;
    inflight_d   = inflight_q;
    inflightPc_d = inflightPc_q;
    halted_d     = halted_q;

    if (flush) begin
      count_d    = '0;
      rdPtr_d    = '0;
      wrPtr_d    = '0;
      inflight_d = 1'b0;
      halted_d   = 1'b0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      inflight_d = accept;
      if (accept) begin
        inflightPc_d = pc_in;
      end
      if (haltHit) begin
        halted_d = 1'b1;
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q      <= '0;
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
      inflight_q   <= 1'b0;
      inflightPc_q <= '0;
      halted_q     <= 1'b0;
    end else begin
      count_q      <= count_d;
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
      halted_q     <= halted_d;
    end
  end

  // Queue storage needs no reset; only entries below count are ever visible.
  always_ff @(posedge clk) begin
    if (push) begin
      instrMem_q[wrPtr_q] <= imem_rdata;
      pcMem_q[wrPtr_q]    <= inflightPc_q;
    end
  end

  // Tracks the current head so instr/instr_pc keep their last value while
  // the queue is empty; reset makes them read 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      holdInstr_q <= '0;
      holdPc_q    <= '0;
    end else if (count_q != '0) begin
      holdInstr_q <= instrMem_q[rdPtr_q];
      holdPc_q    <= pcMem_q[rdPtr_q];
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
//   Directed bench for instr_fetch_queue with a synchronous instruction memory
//   model holding imem[i] = 9'h100 + (i mod 256). Covers reset, streaming,
//   back-pressure, full queue with simultaneous push/pop and wrap, flush,
//   reset mid-operation and halt detection (both macro settings).
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_in = '0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic        flush = 1'b0;
  logic        imem_rd_en;
  logic [11:0] imem_addr;
  logic [8:0]  imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [8:0]  instr;
  logic [31:0] instr_pc;
  logic        halted;

  logic [8:0]  imemArr [4096];
  int          testsRun = 0;
  int          testsFailed = 0;

  instr_fetch_queue dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .flush      (flush),
    .imem_rd_en (imem_rd_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .halted     (halted)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Synchronous instruction memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (imem_rd_en) begin
      imem_rdata <= imemArr[imem_addr];
    end
  end

  // Starts a new cycle and drives inputs just after the edge, then lets
  // the combinational outputs settle before any checks.
  task automatic applyStimulus(input logic pv, input logic [31:0] pc,
                               input logic rdy, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    pc_valid    = pv;
    pc_in       = pc;
    instr_ready = rdy;
    flush       = fl;
    reset       = rs;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      imemArr[i] = {1'b1, 8'(i)};
    end

    // Reset held low: nothing accepted, address still truncates pc_in.
    applyStimulus(1'b1, 32'hABCD_E123, 1'b1, 1'b0, 1'b0);
    checkOutput("rst pc_ready", 32'(pc_ready), 32'd0);
    checkOutput("rst rd_en", 32'(imem_rd_en), 32'd0);
    checkOutput("rst addr wrap", 32'(imem_addr), 32'h123);
    applyStimulus(1'b1, 32'hABCD_E123, 1'b1, 1'b0, 1'b0);
    checkOutput("rst valid", 32'(instr_valid), 32'd0);
    checkOutput("rst instr", 32'(instr), 32'd0);
    checkOutput("rst instr_pc", instr_pc, 32'd0);
    checkOutput("rst halted", 32'(halted), 32'd0);
    checkOutput("rst pc_ready2", 32'(pc_ready), 32'd0);

    // Stream: one instruction per cycle, first one two cycles after accept.
    for (int k = 0; k < 13; k++) begin
      applyStimulus(1'(k < 10), 32'(k), 1'b1, 1'b0, 1'b1);
      if (k < 10) checkOutput("t1 pc_ready", 32'(pc_ready), 32'd1);
      if (k >= 2 && k < 12) begin
        checkOutput("t1 valid", 32'(instr_valid), 32'd1);
        checkOutput("t1 instr", 32'(instr), 32'(9'h100 + 9'(k - 2)));
        checkOutput("t1 instr_pc", instr_pc, 32'(k - 2));
      end else begin
        checkOutput("t1 valid idle", 32'(instr_valid), 32'd0);
      end
    end
    checkOutput("t1 hold instr", 32'(instr), 32'h109);
    checkOutput("t1 hold pc", instr_pc, 32'd9);

    // Back-pressure: decode stalls 8 cycles, credit stops accepts at 4.
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b1, 32'((j < 4) ? j : 4), 1'b0, 1'b0, 1'b1);
      checkOutput("t2 pc_ready", 32'(pc_ready), 32'(j < 4));
      checkOutput("t2 valid", 32'(instr_valid), 32'(j >= 2));
      if (j >= 2) checkOutput("t2 head", 32'(instr), 32'h100);
    end
    checkOutput("t2 head pc", instr_pc, 32'd0);
    for (int r = 0; r < 12; r++) begin
      applyStimulus(1'(r < 8), 32'((r == 0) ? 4 : r + 3), 1'b1, 1'b0, 1'b1);
      if (r < 8) checkOutput("t2 rel pc_ready", 32'(pc_ready), 32'(r != 0));
      if (r < 11) begin
        checkOutput("t2 rel valid", 32'(instr_valid), 32'd1);
        checkOutput("t2 rel instr", 32'(instr), 32'(9'h100 + 9'(r)));
        checkOutput("t2 rel pc", instr_pc, 32'(r));
      end else begin
        checkOutput("t2 drained", 32'(instr_valid), 32'd0);
      end
    end

    // Full queue (3 queued + 1 in flight) with push and pop together.
    for (int c = 0; c < 14; c++) begin
      applyStimulus(1'(c < 10), 32'((c <= 4) ? 32 + c : 31 + c), 1'(c >= 4), 1'b0, 1'b1);
      if (c < 10) checkOutput("t4 pc_ready", 32'(pc_ready), 32'(c != 4));
      if (c >= 2 && c <= 12) begin
        checkOutput("t4 valid", 32'(instr_valid), 32'd1);
        checkOutput("t4 instr", 32'(instr), 32'(9'h120 + 9'((c < 4) ? 0 : c - 4)));
        checkOutput("t4 pc", instr_pc, 32'((c < 4) ? 32 : 28 + c));
      end else begin
        checkOutput("t4 idle", 32'(instr_valid), 32'd0);
      end
    end

    // Flush with pc3, pc4 queued and pc5 in flight, redirect to pc 20.
    applyStimulus(1'b1, 32'd3, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd4, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd5, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd5, 1'b0, 1'b1, 1'b1);
    checkOutput("t3 flush pc_ready", 32'(pc_ready), 32'd0);
    checkOutput("t3 flush rd_en", 32'(imem_rd_en), 32'd0);
    checkOutput("t3 pre head", 32'(instr), 32'h103);
    applyStimulus(1'b1, 32'd20, 1'b1, 1'b0, 1'b1);
    checkOutput("t3 post valid", 32'(instr_valid), 32'd0);
    checkOutput("t3 redirect ready", 32'(pc_ready), 32'd1);
    checkOutput("t3 redirect addr", 32'(imem_addr), 32'd20);
    applyStimulus(1'b0, 32'd21, 1'b1, 1'b0, 1'b1);
    checkOutput("t3 no pc5", 32'(instr_valid), 32'd0);
    applyStimulus(1'b0, 32'd21, 1'b1, 1'b0, 1'b1);
    checkOutput("t3 redirect valid", 32'(instr_valid), 32'd1);
    checkOutput("t3 redirect instr", 32'(instr), 32'h114);
    checkOutput("t3 redirect pc", instr_pc, 32'd20);
    applyStimulus(1'b0, 32'd21, 1'b1, 1'b0, 1'b1);
    checkOutput("t3 empty", 32'(instr_valid), 32'd0);

    // Reset for one cycle with three entries queued.
    applyStimulus(1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd2, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd3, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5 rst pc_ready", 32'(pc_ready), 32'd0);
    checkOutput("t5 rst rd_en", 32'(imem_rd_en), 32'd0);
    checkOutput("t5 pre valid", 32'(instr_valid), 32'd1);
    applyStimulus(1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("t5 post valid", 32'(instr_valid), 32'd0);
    checkOutput("t5 post instr", 32'(instr), 32'd0);
    checkOutput("t5 post pc", instr_pc, 32'd0);
    checkOutput("t5 post ready", 32'(pc_ready), 32'd1);
    applyStimulus(1'b1, 32'd1, 1'b1, 1'b0, 1'b1);
    checkOutput("t5 latency", 32'(instr_valid), 32'd0);
    applyStimulus(1'b0, 32'd2, 1'b1, 1'b0, 1'b1);
    checkOutput("t5 instr0", 32'(instr), 32'h100);
    checkOutput("t5 pc0", instr_pc, 32'd0);
    applyStimulus(1'b0, 32'd2, 1'b1, 1'b0, 1'b1);
    checkOutput("t5 instr1", 32'(instr), 32'h101);
    checkOutput("t5 valid1", 32'(instr_valid), 32'd1);
    applyStimulus(1'b0, 32'd2, 1'b1, 1'b0, 1'b1);
    checkOutput("t5 empty", 32'(instr_valid), 32'd0);

    // Halt word at imem[3].
    imemArr[3] = 9'h1FF;
    for (int c = 0; c < 10; c++) begin
`ifdef FETCH_HALT_DETECT_EN
      applyStimulus(1'(c < 8), 32'((c < 5) ? c : 5), 1'b1, 1'b0, 1'b1);
      if (c < 8) checkOutput("t6 pc_ready", 32'(pc_ready), 32'(c < 5));
      checkOutput("t6 halted", 32'(halted), 32'(c >= 5));
      checkOutput("t6 valid", 32'(instr_valid), 32'(c >= 2 && c <= 6));
      if (c >= 2 && c <= 6) begin
        checkOutput("t6 instr", 32'(instr), 32'((c == 5) ? 9'h1FF : 9'h100 + 9'(c - 2)));
        checkOutput("t6 pc", instr_pc, 32'(c - 2));
      end
`else
      applyStimulus(1'(c < 8), 32'(c), 1'b1, 1'b0, 1'b1);
      if (c < 8) checkOutput("t6 pc_ready", 32'(pc_ready), 32'd1);
      checkOutput("t6 halted", 32'(halted), 32'd0);
      checkOutput("t6 valid", 32'(instr_valid), 32'(c >= 2));
      if (c >= 2) begin
        checkOutput("t6 instr", 32'(instr), 32'((c == 5) ? 9'h1FF : 9'h100 + 9'(c - 2)));
        checkOutput("t6 pc", instr_pc, 32'(c - 2));
      end
`endif
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("t6 flush halted", 32'(halted), 32'd0);
    checkOutput("t6 flush ready", 32'(pc_ready), 32'd1);
    checkOutput("t6 flush valid", 32'(instr_valid), 32'd0);
    imemArr[3] = 9'h103;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
